// File: rtl/aes_pkg.sv
// Shared AES wrapper definitions: data widths, feeder state encoding and a
// helper that places one input word into a 128-bit message block.
package aes_pkg;

    localparam int AES_WORD_W = 32;
    localparam int AES_BLK_W  = 128;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } feeder_state_t;

    // Word 0 clears the rest of the block, so a message that ends early is
    // already zero-padded without any extra pass over the slot.
    function automatic logic [AES_BLK_W-1:0] insert_word(
        input logic [AES_BLK_W-1:0]  blk,
        input logic [AES_WORD_W-1:0] word,
        input logic [1:0]            idx
    );
        logic [AES_BLK_W-1:0] r;
        r = blk;
        case (idx)
            2'd0:    r = {word, {(AES_BLK_W-AES_WORD_W){1'b0}}};
            2'd1:    r[AES_BLK_W-AES_WORD_W-1 -: AES_WORD_W]   = word;
            2'd2:    r[AES_BLK_W-2*AES_WORD_W-1 -: AES_WORD_W] = word;
            default: r[AES_WORD_W-1:0]                         = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_blk_buf.sv
// Two-entry ping-pong message buffer: one slot fills from the word stream while
// the other is held for the AES wrapper until the feeder frees it.
module aes_blk_buf
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [1:0]            wr_idx,
    input  logic [AES_WORD_W-1:0] wr_data,
    input  logic                  close,
    input  logic                  close_last,
    input  logic                  free,
    output logic                  fill_free,
    output logic                  head_full,
    output logic                  head_last,
    output logic [AES_BLK_W-1:0]  head_data,
    output logic                  any_full
);

    logic [AES_BLK_W-1:0] data [2];
    logic [1:0]           full;
    logic [1:0]           last;
    logic                 fill_ptr;
    logic                 head_ptr;

    // The fill slot is only written while empty and the head slot is only
    // freed while full, so free and close never target the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data[i] <= '0;
            end
            full     <= '0;
            last     <= '0;
            fill_ptr <= 1'b0;
            head_ptr <= 1'b0;
        end else begin
            if (free) begin
                full[head_ptr] <= 1'b0;
                head_ptr       <= ~head_ptr;
            end
            if (wr_en && !full[fill_ptr]) begin
                data[fill_ptr] <= insert_word(data[fill_ptr], wr_data, wr_idx);
                if (close) begin
                    full[fill_ptr] <= 1'b1;
                    last[fill_ptr] <= close_last;
                    fill_ptr       <= ~fill_ptr;
                end
            end
        end
    end

    assign fill_free = ~full[fill_ptr];
    assign head_full = full[head_ptr];
    assign head_last = last[head_ptr];
    assign head_data = data[head_ptr];
    assign any_full  = |full;

endmodule

// File: rtl/aes_msg_feeder.sv
// Packs a 32-bit word stream into 128-bit blocks and issues them one at a time
// to the AES wrapper, with a watchdog on the wrapper's busy handshake.
module aes_msg_feeder
    import aes_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [AES_WORD_W-1:0] s_data,
    input  logic                  s_last,
    input  logic                  aes_ready,
    output logic                  aes_run,
    output logic                  aes_fin,
    output logic [AES_BLK_W-1:0]  aes_msg,
    output logic [1:0]            pad_words,
    output logic [CNT_W-1:0]      blk_cnt,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int               TMO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    feeder_state_t        state;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [1:0]           idx;
    logic                 accept;
    logic                 close;
    logic                 buf_free;
    logic                 fill_free;
    logic                 head_full;
    logic                 head_last;
    logic [AES_BLK_W-1:0] head_data;
    logic                 any_full;

    assign s_ready = fill_free;
    assign accept  = s_valid & fill_free;
    assign close   = accept & (s_last | (idx == 2'd3));

    // Freeing is combinational so the slot empties on the same edge the FSM
    // returns to IDLE; IDLE then sees the next head a cycle later.
    assign buf_free = ((state == WAIT_DONE) & aes_ready)
                    | ((state == WAIT_BUSY) & aes_ready & (tmo_cnt == TMO_LAST));

    assign busy = any_full | (state != IDLE);

    aes_blk_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (accept),
        .wr_idx     (idx),
        .wr_data    (s_data),
        .close      (close),
        .close_last (s_last),
        .free       (buf_free),
        .fill_free  (fill_free),
        .head_full  (head_full),
        .head_last  (head_last),
        .head_data  (head_data),
        .any_full   (any_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 2'd0;
            pad_words <= 2'd0;
        end else if (accept) begin
            idx <= close ? 2'd0 : idx + 2'd1;
            if (s_last) begin
                pad_words <= 2'd3 - idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            aes_run     <= 1'b0;
            aes_fin     <= 1'b0;
            aes_msg     <= '0;
            blk_cnt     <= '0;
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            aes_run <= 1'b0;
            aes_fin <= 1'b0;
            case (state)
                IDLE: begin
                    if (head_full && aes_ready) begin
                        aes_run <= 1'b1;
                        aes_fin <= head_last;
                        aes_msg <= head_data;
                        tmo_cnt <= '0;
                        state   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!aes_ready) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (aes_ready) begin
                        blk_cnt <= blk_cnt + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_msg_feeder.sv
// Scoreboard bench for aes_msg_feeder: blocks are queued as they are sent and a
// negedge monitor compares every aes_run issue against the queue head.
module tb_aes_msg_feeder;
    import aes_pkg::*;

    localparam int CNT_W        = 16;
    localparam int BUSY_TIMEOUT = 64;
    localparam int AES_LAT      = 20;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  s_valid;
    logic                  s_ready;
    logic [AES_WORD_W-1:0] s_data;
    logic                  s_last;
    logic                  aes_ready;
    logic                  aes_run;
    logic                  aes_fin;
    logic [AES_BLK_W-1:0]  aes_msg;
    logic [1:0]            pad_words;
    logic [CNT_W-1:0]      blk_cnt;
    logic                  busy;
    logic                  err_timeout;

    typedef struct packed {
        logic [AES_BLK_W-1:0] msg;
        logic                 fin;
    } exp_t;

    exp_t                 exp_q[$];
    exp_t                 mon_e;
    logic [AES_BLK_W-1:0] last_msg = '0;
    int                   checks_total  = 0;
    int                   checks_passed = 0;
    int                   cyc = 0;
    int                   busy_left;
    logic                 model_ignore;

    aes_msg_feeder #(.CNT_W(CNT_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .aes_ready   (aes_ready),
        .aes_run     (aes_run),
        .aes_fin     (aes_fin),
        .aes_msg     (aes_msg),
        .pad_words   (pad_words),
        .blk_cnt     (blk_cnt),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // AES wrapper model: drops ready for AES_LAT cycles after each run pulse
    // unless told to ignore the pulse.
    always @(posedge clk) begin
        if (rst) begin
            aes_ready <= 1'b1;
            busy_left <= 0;
        end else if (aes_run && !model_ignore) begin
            aes_ready <= 1'b0;
            busy_left <= AES_LAT;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) aes_ready <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [AES_BLK_W-1:0] act,
                               input logic [AES_BLK_W-1:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && aes_run) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_run", aes_msg, '0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("aes_msg", aes_msg, mon_e.msg);
                checkOutput("aes_fin", aes_fin, mon_e.fin);
                last_msg = mon_e.msg;
            end
        end else if (!rst && aes_ready === 1'b0) begin
            checkOutput("msg_stable", aes_msg, last_msg);
        end
    end

    task automatic applyStimulus(input logic [31:0] w, input logic l);
        int g = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        s_last  = l;
        while (!s_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            checkOutput("s_ready_wait", s_ready, 1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // blk is given already zero-padded past word n-1.
    task automatic sendBlock(input logic [AES_BLK_W-1:0] blk, input int n, input logic last);
        exp_t e;
        e.msg = blk;
        e.fin = last;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            applyStimulus(blk[AES_BLK_W-1-32*i -: 32], last && (i == n - 1));
        end
    endtask

    task automatic waitIdle();
        int g = 0;
        @(negedge clk);
        while ((busy || !aes_ready) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        checkOutput("wait_idle", {busy, ~aes_ready}, 0);
    endtask

    task automatic waitRun(output int run_cyc);
        int g = 0;
        @(negedge clk);
        while (!aes_run && g < 500) begin
            @(negedge clk);
            g++;
        end
        checkOutput("wait_run", aes_run, 1);
        run_cyc = cyc;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int run_cyc;
        int g;
        rst          = 1'b1;
        s_valid      = 1'b0;
        s_data       = '0;
        s_last       = 1'b0;
        model_ignore = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_aes_run", aes_run, 0);
        checkOutput("rst_aes_fin", aes_fin, 0);
        checkOutput("rst_aes_msg", aes_msg, 0);
        checkOutput("rst_pad_words", pad_words, 0);
        checkOutput("rst_blk_cnt", blk_cnt, 0);
        checkOutput("rst_err_timeout", err_timeout, 0);
        rst = 1'b0;

        $display("[TB] full four-word message");
        sendBlock(128'h00112233_44556677_8899AABB_CCDDEEFF, 4, 1'b1);
        waitIdle();
        checkOutput("t1_pad_words", pad_words, 0);
        checkOutput("t1_blk_cnt", blk_cnt, 1);

        $display("[TB] two-word message with padding");
        sendBlock(128'hDEADBEEF_01234567_00000000_00000000, 2, 1'b1);
        waitIdle();
        checkOutput("t2_pad_words", pad_words, 2);
        checkOutput("t2_blk_cnt", blk_cnt, 2);

        $display("[TB] three blocks back-to-back");
        doReset();
        sendBlock(128'h10000001_10000002_10000003_10000004, 4, 1'b0);
        sendBlock(128'h20000001_20000002_20000003_20000004, 4, 1'b0);
        @(negedge clk);
        checkOutput("t3_s_ready_both_full", s_ready, 0);
        checkOutput("t3_busy", busy, 1);
        sendBlock(128'h30000001_30000002_30000003_00000000, 3, 1'b1);
        waitIdle();
        checkOutput("t3_blk_cnt", blk_cnt, 3);
        checkOutput("t3_pad_words", pad_words, 1);

        $display("[TB] busy timeout");
        model_ignore = 1'b1;
        sendBlock(128'hA0000001_A0000002_A0000003_A0000004, 4, 1'b0);
        waitRun(run_cyc);
        @(negedge clk);
        @(negedge clk);
        model_ignore = 1'b0;
        sendBlock(128'hB0000001_00000000_00000000_00000000, 1, 1'b1);
        g = 0;
        while (!err_timeout && g < 500) begin
            @(negedge clk);
            g++;
        end
        checkOutput("t4_err_timeout", err_timeout, 1);
        checkOutput("t4_timeout_cycles", cyc - run_cyc, BUSY_TIMEOUT);
        checkOutput("t4_blk_cnt_unchanged", blk_cnt, 3);
        waitIdle();
        checkOutput("t4_blk_cnt_next", blk_cnt, 4);
        checkOutput("t4_pad_words", pad_words, 3);
        checkOutput("t4_err_sticky", err_timeout, 1);

        $display("[TB] reset during WAIT_DONE");
        sendBlock(128'hC0000001_C0000002_C0000003_C0000004, 4, 1'b0);
        g = 0;
        while (aes_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        checkOutput("t5_aes_busy", aes_ready, 0);
        sendBlock(128'hD0000001_D0000002_D0000003_D0000004, 4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_s_ready", s_ready, 1);
        checkOutput("t5_aes_run", aes_run, 0);
        checkOutput("t5_blk_cnt", blk_cnt, 0);
        checkOutput("t5_err_timeout", err_timeout, 0);
        rst = 1'b0;

        $display("[TB] blk_cnt wrap");
        @(negedge clk);
        force dut.blk_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.blk_cnt;
        sendBlock(128'hCAFEF00D_00000000_00000000_00000000, 1, 1'b1);
        waitIdle();
        checkOutput("t6_blk_cnt_wrap", blk_cnt, 0);
        checkOutput("t6_pad_words", pad_words, 3);

        repeat (5) @(negedge clk);
        checkOutput("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
